cacheline_arbiter: RTL

- Shares the single physical-memory / L2 cacheline port between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits between the two L1 caches and the memory side, below the pipeline's memory stage.
- Serialises one cacheline transaction at a time. D-cache has priority; a bounded-streak rule guarantees I-cache forward progress.
- Latches each granted request and steers the response back only to the owner.

---
 rtl/cacheline_arbiter_pkg.sv | 21 ++
 rtl/arb_streak_counter.sv | 28 ++
 rtl/cacheline_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and helpers for the L1 -> L2 cacheline port arbiter.
package cacheline_arbiter_pkg;

  // Upper bound on the configurable D-grant streak.
  localparam int unsigned STREAK_LIMIT = 15;

  // Arbiter states: free port, one of three grants, and the post-response cycle.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT_I,
    ST_GRANT_D_RD,
    ST_GRANT_D_WR,
    ST_DONE
  } arb_state_t;

  // Counter width needed to hold 0..max_streak.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive D grants taken while an I request waits.
module arb_streak_counter
  import cacheline_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = streak_width(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clear,
  output logic at_max_c
);

  logic [W-1:0] count;

  assign at_max_c = (count == W'(MAX));

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !at_max_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Serialises I-cache and D-cache line transactions onto one memory port.
// D has priority; after MAX_D_STREAK D grants with I waiting, I wins once.
module cacheline_arbiter
  import cacheline_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state;
  logic       arb_en;
  logic       i_pend;
  logic       d_pend;
  logic       pick_i;
  logic       pick_d;
  logic       streak_inc;
  logic       streak_clr;
  logic       streak_at_max;

  arb_streak_counter #(
    .MAX (MAX_D_STREAK)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .inc      (streak_inc),
    .clear    (streak_clr),
    .at_max_c (streak_at_max)
  );

  // Winner selection; only acts while the port is free (IDLE or DONE).
  always_comb begin
    arb_en     = 1'b0;
    i_pend     = 1'b0;
    d_pend     = 1'b0;
    pick_d     = 1'b0;
    pick_i     = 1'b0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    arb_en     = (state == ST_IDLE) || (state == ST_DONE);
    i_pend     = i_read;
    d_pend     = d_read | d_write;
    pick_d     = arb_en && d_pend && (!i_pend || !streak_at_max);
    pick_i     = arb_en && i_pend && !pick_d;
    streak_inc = pick_d && i_pend;
    streak_clr = pick_i || (pick_d && !i_pend);
  end

  // Response steering: data fans out to both, the pulse only to the owner.
  always_comb begin
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
    i_resp  = mem_resp && (state == ST_GRANT_I);
    d_resp  = mem_resp && ((state == ST_GRANT_D_RD) || (state == ST_GRANT_D_WR));
  end

  // State, registered memory command and the latched address/write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state     <= ST_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (pick_d) begin
            mem_addr <= d_addr;
            // A simultaneous read+write request is treated as a writeback.
            if (d_write) begin
              state     <= ST_GRANT_D_WR;
              mem_write <= 1'b1;
              mem_wdata <= d_wdata;
            end else begin
              state    <= ST_GRANT_D_RD;
              mem_read <= 1'b1;
            end
          end else if (pick_i) begin
            state    <= ST_GRANT_I;
            mem_read <= 1'b1;
            mem_addr <= i_addr;
          end
        end
        ST_GRANT_I, ST_GRANT_D_RD, ST_GRANT_D_WR: begin
          // DONE gives the requester a cycle to drop its request.
          if (mem_resp) begin
            state     <= ST_DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
